bit_permute_unit: RTL and testbench
===================================

BIT_PERMUTE_UNIT -- requirements
Module: bit_permute_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width in bits, an even value of at least 2.
REQ-002 SHALL have parameter GROUP, default 8: group size in bits, with WIDTH mod GROUP == 0.
REQ-003 SHALL have port clk  input  1: the single clock; every register updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: the reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1: the producer offers data.
REQ-006 SHALL have port in_ready  output  1: the unit can accept data.
REQ-007 SHALL have port in_data  input  WIDTH: the operand.
REQ-008 SHALL have port in_mode  input  2: the permutation select, sampled with in_data.
REQ-009 SHALL have port out_valid  output  1: a result is available.
REQ-010 SHALL have port out_ready  input  1: the consumer accepts the result.
REQ-011 SHALL have port out_data  output  WIDTH: the permuted result.

Function
REQ-012 SHALL accept a word only on a cycle where in_valid and in_ready are both 1 (push), and retire a word only on a cycle where out_valid and out_ready are both 1 (pop).
REQ-013 SHALL apply the permutation at push time and store the permuted result in a 2-entry FIFO.
REQ-014 SHALL implement mode 0 PASS: out equals in.
REQ-015 SHALL implement mode 1 BITREV: out[i] = in[WIDTH-1-i] across the full width.
REQ-016 SHALL implement mode 2 GRPREV: reverse the order of the GROUP-bit groups and keep bit order within each group.
REQ-017 SHALL implement mode 3 INGRP: reverse the bits within each group and keep the group positions.
REQ-018 SHALL give a latency of exactly 1 cycle: a word pushed at edge N shows out_valid=1 after edge N and can be popped at edge N+1 at the earliest.
REQ-019 SHALL present the oldest entry on out_data, and drive out_data to 0 whenever out_valid is 0.
REQ-020 SHALL drive in_ready = (occupancy < 2), decoded from registered state only; there is no combinational path from out_ready to in_ready.
REQ-021 SHALL, on a simultaneous push and pop at occupancy 1, keep occupancy at 1 and make the new word the head on the next cycle.
REQ-022 SHALL, at occupancy 2, refuse any push; a pop that cycle raises in_ready on the next cycle.
REQ-023 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain one word per cycle when out_ready stays high.

Reset
REQ-025 SHALL, while rst_n=0, force occupancy 0, FIFO pointers 0, out_valid 0, out_data 0 and in_ready 1, asynchronously.
REQ-026 SHALL, on reset asserted mid-transfer, discard all stored words; no pop completes during reset.
REQ-027 SHALL make the first push possible at the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro BITPERM_CNT_EN defined, add output port xfer_count (16 bits), which is 0 at reset, increments on each pop and wraps from 0xFFFF to 0x0000.
REQ-029 SHALL, without BITPERM_CNT_EN, omit the xfer_count port and its register entirely.

Structure
REQ-030 SHALL place the mode encodings (MODE_PASS=0, MODE_BITREV=1, MODE_GRPREV=2, MODE_INGRP=3) and the FIFO depth constant (2) in shared package bitperm_pkg.
REQ-031 SHALL implement the permutation in one combinational sub-module, bit_permute_comb (parameters WIDTH and GROUP; ports in, mode, out), instantiated once in front of the FIFO write port.

Verification
REQ-032 SHALL cover, with WIDTH=16 and GROUP=8: push 0x0001 in each of modes 0, 1, 2, 3 with out_ready=1 -> out_data 0x0001, 0x8000, 0x0100, 0x0080, each one cycle after its push.
REQ-033 SHALL cover: out_ready=0, push 0x1234 then 0xABCD in mode 2 -> in_ready=0 after the second push; third offer refused; then out_ready=1 -> pops 0x3412, then 0xCDAB.
REQ-034 SHALL cover: in_valid=1 and out_ready=1 held for 20 cycles with incrementing data in mode 0 -> 20 pops in order, with in_ready constantly 1.
REQ-035 SHALL cover: rst_n pulsed low with 2 words stored -> immediately out_valid=0, out_data=0, in_ready=1; the stored words are never popped.
REQ-036 SHALL cover, with BITPERM_CNT_EN: 0xFFFF forced pops -> xfer_count=0xFFFF; one more pop -> 0x0000.
REQ-037 SHALL cover, with WIDTH=32 and GROUP=4: push 0x12345678 in mode 2 -> 0x87654321; in mode 1 -> 0x1E6A2C48.

Source files
------------

// File: rtl/bitperm_pkg.sv
// bitperm_pkg -- shared constants for the bit permutation unit.
//   mode_e     : permutation select encodings (PASS, BITREV, GRPREV, INGRP)
//   FIFO_DEPTH : number of result entries buffered behind the permuter
package bitperm_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_BITREV = 2'd1,
        MODE_GRPREV = 2'd2,
        MODE_INGRP  = 2'd3
    } mode_e;

    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/bit_permute_comb.sv
// bit_permute_comb -- purely combinational bit permuter.
//   in   : operand, WIDTH bits
//   mode : permutation select (see bitperm_pkg::mode_e)
//   out  : permuted operand, WIDTH bits
// WIDTH must be a multiple of GROUP.
module bit_permute_comb
    import bitperm_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 8
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned NGRP = WIDTH / GROUP;

    always_comb begin
        out = '0;
        unique case (mode_e'(mode))
            MODE_PASS: out = in;
            MODE_BITREV: begin
                for (int unsigned i = 0; i < WIDTH; i++)
                    out[i] = in[WIDTH-1-i];
            end
            // group g of the result takes group NGRP-1-g of the operand
            MODE_GRPREV: begin
                for (int unsigned g = 0; g < NGRP; g++)
                    for (int unsigned b = 0; b < GROUP; b++)
                        out[g*GROUP + b] = in[(NGRP-1-g)*GROUP + b];
            end
            MODE_INGRP: begin
                for (int unsigned g = 0; g < NGRP; g++)
                    for (int unsigned b = 0; b < GROUP; b++)
                        out[g*GROUP + b] = in[g*GROUP + GROUP-1-b];
            end
            default: out = in;
        endcase
    end

endmodule

// File: rtl/bit_permute_unit.sv
// bit_permute_unit -- valid/ready bit permuter with a 2-entry result FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data/in_mode sampled on push
//   out_valid/out_ready : output handshake; out_data is the oldest result,
//                         forced to 0 while out_valid is 0
//   xfer_count          : 16-bit wrapping pop counter, only present when the
//                         macro BITPERM_CNT_EN is defined
// The permutation is applied before the FIFO write, so each result appears
// one cycle after its push. in_ready depends only on registered occupancy.
module bit_permute_unit
    import bitperm_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BITPERM_CNT_EN
   ,output logic [15:0]      xfer_count
`endif
);

    logic [WIDTH-1:0] perm;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    bit_permute_comb #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) u_perm (
        .in   (in_data),
        .mode (in_mode),
        .out  (perm)
    );

    assign in_ready  = (count_q < 2'(FIFO_DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= perm;
        end
    end

`ifdef BITPERM_CNT_EN
    logic [15:0] xfer_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   xfer_q <= '0;
        else if (pop) xfer_q <= xfer_q + 16'd1;
    end

    assign xfer_count = xfer_q;
`endif

endmodule

// File: tb/tb_bit_permute_unit.sv
// tb_bit_permute_unit -- directed, table-driven checks of bit_permute_unit
// (16/8 instance plus a 32/4 instance). Define BITPERM_CNT_EN to also
// exercise the pop counter.
module tb_bit_permute_unit;
    import bitperm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_data;

    logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic [31:0] in_data2 = '0;
    logic [1:0]  in_mode2 = '0;
    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;

`ifdef BITPERM_CNT_EN
    logic [15:0] xfer_count, xfer_count2;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bit_permute_unit #(.WIDTH(16), .GROUP(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BITPERM_CNT_EN
       ,.xfer_count(xfer_count)
`endif
    );

    bit_permute_unit #(.WIDTH(32), .GROUP(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_mode(in_mode2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
`ifdef BITPERM_CNT_EN
       ,.xfer_count(xfer_count2)
`endif
    );

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t v16 [10];
    vec_t v32 [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // advance one clock, then settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v16[0] = '{2'd0, 32'h0001, 32'h0001};
        v16[1] = '{2'd1, 32'h0001, 32'h8000};
        v16[2] = '{2'd2, 32'h0001, 32'h0100};
        v16[3] = '{2'd3, 32'h0001, 32'h0080};
        v16[4] = '{2'd1, 32'h1234, 32'h2C48};
        v16[5] = '{2'd3, 32'h1234, 32'h482C};
        v16[6] = '{2'd2, 32'hABCD, 32'hCDAB};
        v16[7] = '{2'd0, 32'hBEEF, 32'hBEEF};
        v16[8] = '{2'd3, 32'h00F0, 32'h000F};
        v16[9] = '{2'd1, 32'hFFFF, 32'hFFFF};
        v32[0] = '{2'd2, 32'h12345678, 32'h87654321};
        v32[1] = '{2'd1, 32'h12345678, 32'h1E6A2C48};

        // reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // release away from the edge; the very next edge must accept a push
        @(negedge clk);
        rst_n = 1'b1;

        // 16/8 vectors: push, result visible one cycle later, then popped
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            out_ready = 1'b1;
            in_mode = v16[i].mode;
            in_data = v16[i].data[15:0];
            check($sformatf("v16[%0d]_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            check($sformatf("v16[%0d]_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v16[%0d]_data", i), 32'(out_data), v16[i].exp);
            tick();
            check($sformatf("v16[%0d]_drained", i), 32'(out_valid), 32'd0);
            check($sformatf("v16[%0d]_zero", i), 32'(out_data), 32'd0);
        end

        // 32/4 vectors
        for (int i = 0; i < 2; i++) begin
            in_valid2 = 1'b1;
            out_ready2 = 1'b1;
            in_mode2 = v32[i].mode;
            in_data2 = v32[i].data;
            tick();
            in_valid2 = 1'b0;
            check($sformatf("v32[%0d]_valid", i), 32'(out_valid2), 32'd1);
            check($sformatf("v32[%0d]_data", i), out_data2, v32[i].exp);
            tick();
            check($sformatf("v32[%0d]_drained", i), 32'(out_valid2), 32'd0);
        end

        // fill to depth 2 with consumer stalled, refuse third offer
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 2'd2;
        in_data = 16'h1234;
        tick();
        check("full_ready_after1", 32'(in_ready), 32'd1);
        check("full_head1", 32'(out_data), 32'h3412);
        in_data = 16'hABCD;
        tick();
        check("full_ready_after2", 32'(in_ready), 32'd0);
        check("full_head2", 32'(out_data), 32'h3412);
        in_data = 16'h5555;
        tick();
        check("full_refused_ready", 32'(in_ready), 32'd0);
        check("full_stall_valid", 32'(out_valid), 32'd1);
        check("full_stall_data", 32'(out_data), 32'h3412);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("full_pop2_data", 32'(out_data), 32'hCDAB);
        check("full_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("full_empty", 32'(out_valid), 32'd0);

        // streaming: one word per cycle, in order, in_ready always high
        in_mode = 2'd0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 16'(i + 16'h0100);
            check($sformatf("stream[%0d]_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            check($sformatf("stream[%0d]_data", i), 32'(out_data), 32'(i + 16'h0100));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);

        // reset with two stored words discards them immediately
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'hAAAA;
        tick();
        in_data = 16'h5555;
        tick();
        in_valid = 1'b0;
        check("prerst_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        check("inrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        check("postrst_out_data", 32'(out_data), 32'd0);

`ifdef BITPERM_CNT_EN
        // counter: fresh reset, then one push edge followed by a pop every edge
        check("cnt_after_reset", 32'(xfer_count), 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = 16'h0000;
        tick();
        check("cnt_first_push", 32'(xfer_count), 32'd0);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        check("cnt_ffff", 32'(xfer_count), 32'h0000FFFF);
        tick();
        check("cnt_wrap", 32'(xfer_count), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
